// File: rtl/mc_datapath.sv
// Multi-cycle RV32I datapath: PC, register file, IR/MDR/A/B/ALUOut/PCPlus4,
// immediate generator and ALU, driven by the control FSM's per-cycle word.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_mem_addr,
  input  logic        we_ir,
  input  logic        sel_alu_src_a,
  input  logic [1:0]  sel_alu_src_b,
  input  logic [1:0]  alu_op,
  input  logic [1:0]  sel_result,
  input  logic        we_pc,
  input  logic        we_mem,
  input  logic        we_rf,
  input  logic        we_pc_plus_4,
  input  logic        we_alu_reg,
  output logic [6:0]  opcode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  dbg_rf_addr,
  output logic [31:0] dbg_rf_data,
  output logic [31:0] dbg_pc
);

  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic [31:0] pc_plus_4;
  logic [31:0] rf [32];

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        funct7b5;

  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_y;
  logic [31:0] result;
  logic [4:0]  shamt;

  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign funct7b5 = ir[30];
  assign opcode   = ir[6:0];

  assign rf_rs1      = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rf_rs2      = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign dbg_rf_data = (dbg_rf_addr == 5'd0) ? 32'd0 : rf[dbg_rf_addr];
  assign dbg_pc      = pc;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};

  // OldPC feeds JAL's target; fetch still sees the live PC
  always_comb begin
    src_a = pc;
    if (sel_alu_src_a)
      src_a = a;
    else if (sel_alu_src_b == 2'b11)
      src_a = old_pc;
  end

  always_comb begin
    src_b = b;
    unique case (sel_alu_src_b)
      2'b00: src_b = b;
      2'b01: src_b = (opcode == 7'b0100011) ? imm_s : imm_i;
      2'b10: src_b = 32'd4;
      2'b11: src_b = imm_j;
    endcase
  end

  assign shamt = src_b[4:0];

  always_comb begin
    alu_y = src_a + src_b;
    if (alu_op == 2'b01 || alu_op == 2'b10) begin
      unique case (funct3)
        3'b000: begin
          if (alu_op == 2'b01 && funct7b5)
            alu_y = src_a - src_b;
          else
            alu_y = src_a + src_b;
        end
        3'b001: alu_y = src_a << shamt;
        3'b010: alu_y = {31'd0, $signed(src_a) < $signed(src_b)};
        3'b011: alu_y = {31'd0, src_a < src_b};
        3'b100: alu_y = src_a ^ src_b;
        3'b101: begin
          if (funct7b5)
            alu_y = $signed(src_a) >>> shamt;
          else
            alu_y = src_a >> shamt;
        end
        3'b110: alu_y = src_a | src_b;
        3'b111: alu_y = src_a & src_b;
      endcase
    end
  end

  always_comb begin
    result = alu_out;
    unique case (sel_result)
      2'b00: result = alu_out;
      2'b01: result = mdr;
      2'b10: result = pc_plus_4;
      2'b11: result = imm_u;
    endcase
  end

  assign mem_addr  = sel_mem_addr ? alu_out : pc;
  assign mem_wdata = b;
  assign mem_we    = we_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      old_pc    <= '0;
      ir        <= '0;
      mdr       <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      pc_plus_4 <= '0;
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else begin
      a   <= rf_rs1;
      b   <= rf_rs2;
      mdr <= mem_rdata;
      if (we_ir) begin
        ir     <= mem_rdata;
        old_pc <= pc;
      end
      if (we_pc)
        pc <= alu_y;
      if (we_pc_plus_4)
        pc_plus_4 <= alu_y;
      if (we_alu_reg)
        alu_out <= alu_y;
      if (we_rf && rd != 5'd0)
        rf[rd] <= result;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: plays the control FSM's state words and checks
// results against an instruction-level RV32I model.
module tb_mc_datapath;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_mem_addr;
  logic        we_ir;
  logic        sel_alu_src_a;
  logic [1:0]  sel_alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  sel_result;
  logic        we_pc;
  logic        we_mem;
  logic        we_rf;
  logic        we_pc_plus_4;
  logic        we_alu_reg;
  logic [6:0]  opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [4:0]  dbg_rf_addr;
  logic [31:0] dbg_rf_data;
  logic [31:0] dbg_pc;

  mc_datapath #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .sel_mem_addr(sel_mem_addr), .we_ir(we_ir),
    .sel_alu_src_a(sel_alu_src_a), .sel_alu_src_b(sel_alu_src_b),
    .alu_op(alu_op), .sel_result(sel_result),
    .we_pc(we_pc), .we_mem(we_mem), .we_rf(we_rf),
    .we_pc_plus_4(we_pc_plus_4), .we_alu_reg(we_alu_reg),
    .opcode(opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .dbg_rf_addr(dbg_rf_addr), .dbg_rf_data(dbg_rf_data),
    .dbg_pc(dbg_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk)
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [31:0] m_mem [logic [31:0]];

  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_we;

  typedef enum int {
    S_IDLE, S_FETCH, S_DEC, S_EXE_R, S_EXE_I, S_EXE_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_JAL, S_WB_PC4, S_WB_U
  } st_t;

  task automatic drive(input st_t s);
    sel_mem_addr = 0; we_ir = 0; sel_alu_src_a = 0;
    sel_alu_src_b = 2'b00; alu_op = 2'b00; sel_result = 2'b00;
    we_pc = 0; we_mem = 0; we_rf = 0;
    we_pc_plus_4 = 0; we_alu_reg = 0;
    case (s)
      S_FETCH: begin
        we_ir = 1; sel_alu_src_b = 2'b10;
        we_pc = 1; we_pc_plus_4 = 1;
      end
      S_DEC: begin sel_alu_src_b = 2'b11; we_alu_reg = 1; end
      S_EXE_R: begin
        sel_alu_src_a = 1; alu_op = 2'b01; we_alu_reg = 1;
      end
      S_EXE_I: begin
        sel_alu_src_a = 1; sel_alu_src_b = 2'b01;
        alu_op = 2'b10; we_alu_reg = 1;
      end
      S_EXE_ADDR: begin
        sel_alu_src_a = 1; sel_alu_src_b = 2'b01; we_alu_reg = 1;
      end
      S_MEM_RD: sel_mem_addr = 1;
      S_MEM_WR: begin sel_mem_addr = 1; we_mem = 1; end
      S_WB_ALU: begin sel_result = 2'b00; we_rf = 1; end
      S_WB_MEM: begin sel_result = 2'b01; we_rf = 1; end
      S_JAL: begin sel_alu_src_b = 2'b11; we_pc = 1; end
      S_WB_PC4: begin sel_result = 2'b10; we_rf = 1; end
      S_WB_U: begin sel_result = 2'b11; we_rf = 1; end
      default: ;
    endcase
  endtask

  task automatic run(input st_t s);
    @(negedge clk);
    drive(s);
    #2;
    if (s == S_MEM_WR) begin
      obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
    end
    @(posedge clk);
    #1;
    drive(S_IDLE);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3,
    input logic alt, input logic is_r,
    input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (f3)
      3'd0: if (is_r && alt) return x - y; else return x + y;
      3'd1: return x << sh;
      3'd2: if ($signed(x) < $signed(y)) return 1; else return 0;
      3'd3: if (x < y) return 1; else return 0;
      3'd4: return x ^ y;
      3'd5: if (alt) return $signed(x) >>> sh; else return x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic iss(input logic [31:0] ins);
    logic [31:0] x, y, ii, is, ij, r, nxt;
    logic [4:0]  rd;
    logic        wr;
    x  = m_rf[ins[19:15]];
    y  = m_rf[ins[24:20]];
    rd = ins[11:7];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    r = 0; wr = 0; nxt = m_pc + 4;
    case (ins[6:0])
      7'h33: begin r = ref_alu(ins[14:12], ins[30], 1'b1, x, y); wr = 1; end
      7'h13: begin r = ref_alu(ins[14:12], ins[30], 1'b0, x, ii); wr = 1; end
      7'h03: begin
        r = m_mem.exists(x + ii) ? m_mem[x + ii] : 32'd0; wr = 1;
      end
      7'h23: m_mem[x + is] = y;
      7'h6f: begin r = m_pc + 4; wr = 1; nxt = m_pc + ij; end
      7'h37: begin r = {ins[31:12], 12'h000}; wr = 1; end
      default: ;
    endcase
    if (wr && rd != 0) m_rf[rd] = r;
    m_pc = nxt;
  endtask

  task automatic fetch(input logic [31:0] ins);
    mem[m_pc[11:2]] = ins;
    run(S_FETCH);
  endtask

  task automatic finish_instr(input logic [31:0] ins);
    run(S_DEC);
    case (ins[6:0])
      7'h33: begin run(S_EXE_R); run(S_WB_ALU); end
      7'h13: begin run(S_EXE_I); run(S_WB_ALU); end
      7'h03: begin run(S_EXE_ADDR); run(S_MEM_RD); run(S_WB_MEM); end
      7'h23: begin run(S_EXE_ADDR); run(S_MEM_WR); end
      7'h6f: begin run(S_JAL); run(S_WB_PC4); end
      7'h37: run(S_WB_U);
      default: ;
    endcase
    iss(ins);
  endtask

  task automatic exec(input logic [31:0] ins);
    fetch(ins);
    finish_instr(ins);
  endtask

  task automatic reg_check(input logic [4:0] r, input string tag);
    dbg_rf_addr = r;
    #1;
    checks++;
    if (dbg_rf_data !== m_rf[r]) begin
      errors++;
      $display("FAIL %s x%0d: got %h expected %h",
               tag, r, dbg_rf_data, m_rf[r]);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    drive(S_IDLE);
    dbg_rf_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_pc = RPC;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    checks++;
    if (dbg_pc !== RPC) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", dbg_pc, RPC);
    end
    checks++;
    if (opcode !== 7'h00) begin
      errors++; $display("FAIL reset_opcode: got %h expected 00", opcode);
    end
    checks++;
    if (mem_addr !== RPC) begin
      errors++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, RPC);
    end
    for (int i = 0; i < 32; i++) reg_check(5'(i), "reset_rf");
  endtask

  task automatic test_fetch_addi;
    logic [31:0] ins;
    ins = 32'h00500093;
    fetch(ins);
    checks++;
    if (dbg_pc !== 32'h104) begin
      errors++; $display("FAIL fetch_pc: got %h expected 00000104", dbg_pc);
    end
    checks++;
    if (opcode !== 7'h13) begin
      errors++; $display("FAIL fetch_opcode: got %h expected 13", opcode);
    end
    finish_instr(ins);
    reg_check(5'd1, "addi");
    checks++;
    if (m_rf[1] !== 32'd5 || dbg_rf_data !== 32'd5) begin
      errors++; $display("FAIL addi_x1: got %h expected 5", dbg_rf_data);
    end
  endtask

  task automatic test_r_type;
    exec(32'h00108133);
    dbg_rf_addr = 2; #1;
    checks++;
    if (dbg_rf_data !== 32'd10) begin
      errors++; $display("FAIL add_x2: got %h expected 0000000a", dbg_rf_data);
    end
    exec(32'h401101b3);
    dbg_rf_addr = 3; #1;
    checks++;
    if (dbg_rf_data !== 32'd5) begin
      errors++; $display("FAIL sub_x3: got %h expected 00000005", dbg_rf_data);
    end
  endtask

  task automatic test_mem;
    obs_we = 0;
    exec(32'h00202423);
    checks++;
    if (obs_addr !== 32'd8 || obs_wdata !== 32'd10 || obs_we !== 1'b1) begin
      errors++;
      $display("FAIL sw_port: got addr %h data %h we %b expected 8 a 1",
               obs_addr, obs_wdata, obs_we);
    end
    checks++;
    if (mem[2] !== m_mem[32'd8]) begin
      errors++; $display("FAIL sw_store: got %h expected %h", mem[2], m_mem[32'd8]);
    end
    mem[2] = 32'hDEADBEEF;
    m_mem[32'd8] = 32'hDEADBEEF;
    exec(enc_i(12'd8, 5'd0, 3'd2, 5'd4, 7'h03));
    dbg_rf_addr = 4; #1;
    checks++;
    if (dbg_rf_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_x4: got %h expected deadbeef", dbg_rf_data);
    end
  endtask

  task automatic test_jal;
    logic [31:0] ins;
    exec(enc_j(21'(32'h200 - m_pc), 5'd0));
    checks++;
    if (dbg_pc !== 32'h200) begin
      errors++; $display("FAIL jal_hop_pc: got %h expected 00000200", dbg_pc);
    end
    ins = enc_j(21'd16, 5'd1);
    fetch(ins);
    run(S_DEC);
    run(S_JAL);
    checks++;
    if (dbg_pc !== 32'h210) begin
      errors++; $display("FAIL jal_pc: got %h expected 00000210", dbg_pc);
    end
    run(S_WB_PC4);
    iss(ins);
    dbg_rf_addr = 1; #1;
    checks++;
    if (dbg_rf_data !== 32'h204) begin
      errors++; $display("FAIL jal_link: got %h expected 00000204", dbg_rf_data);
    end
  endtask

  task automatic test_lui_x0;
    exec(32'h123452b7);
    dbg_rf_addr = 5; #1;
    checks++;
    if (dbg_rf_data !== 32'h12345000) begin
      errors++; $display("FAIL lui_x5: got %h expected 12345000", dbg_rf_data);
    end
    exec(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));
    dbg_rf_addr = 0; #1;
    checks++;
    if (dbg_rf_data !== 32'd0) begin
      errors++; $display("FAIL x0_write: got %h expected 00000000", dbg_rf_data);
    end
  endtask

  task automatic test_random;
    logic [31:0] ins;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    for (int n = 0; n < 80; n++) begin
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      sh  = 5'($urandom_range(0, 31));
      f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      case ($urandom_range(0, 2))
        0: begin
          if (f3 != 3'd0 && f3 != 3'd5) f7 = 7'h00;
          ins = enc_r(f7, rs2, rs1, f3, rd);
        end
        1: begin
          imm = 12'($urandom);
          if (f3 == 3'd1) imm = {7'h00, sh};
          if (f3 == 3'd5) imm = {f7, sh};
          ins = enc_i(imm, rs1, f3, rd, 7'h13);
        end
        default: ins = {20'($urandom), rd, 7'h37};
      endcase
      exec(ins);
      reg_check(rd, "rand_rd");
      checks++;
      if (dbg_pc !== m_pc) begin
        errors++; $display("FAIL rand_pc: got %h expected %h", dbg_pc, m_pc);
      end
    end
    for (int i = 0; i < 32; i++) reg_check(5'(i), "rand_final");
  endtask

  task automatic test_rst_mid;
    exec(enc_i(12'h123, 5'd0, 3'd0, 5'd1, 7'h13));
    fetch(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd6));
    run(S_DEC);
    @(negedge clk);
    drive(S_EXE_R);
    we_rf = 1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    drive(S_IDLE);
    m_pc = RPC;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    checks++;
    if (dbg_pc !== RPC) begin
      errors++; $display("FAIL rst_mid_pc: got %h expected %h", dbg_pc, RPC);
    end
    checks++;
    if (opcode !== 7'h00) begin
      errors++; $display("FAIL rst_mid_opcode: got %h expected 00", opcode);
    end
    sel_mem_addr = 1; #1;
    checks++;
    if (mem_addr !== 32'd0) begin
      errors++; $display("FAIL rst_mid_aluout: got %h expected 00000000", mem_addr);
    end
    sel_mem_addr = 0;
    reg_check(5'd6, "rst_mid_x6");
    reg_check(5'd1, "rst_mid_x1");
    exec(32'h00500093);
    reg_check(5'd1, "post_rst_addi");
    checks++;
    if (dbg_pc !== RPC + 4) begin
      errors++; $display("FAIL post_rst_pc: got %h expected %h", dbg_pc, RPC + 4);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset;
    test_fetch_addi;
    test_r_type;
    test_mem;
    test_jal;
    test_lui_x0;
    test_random;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Multi-cycle RV32I datapath that executes the control word produced each cycle by the multi-cycle control FSM.
- Holds the architectural state: PC and the 32x32 register file.
- Holds the non-architectural registers: OldPC, IR, MDR, A, B, ALUOut and PCPlus4.
- Contains the immediate generator and the ALU, and returns the IR opcode to the FSM.
- Connects to a single unified instruction/data memory with combinational read and synchronous write.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sel_mem_addr  in  1  memory address select: 0 = PC, 1 = ALUOut.
- we_ir  in  1  load IR and OldPC.
- sel_alu_src_a  in  1  ALU operand A: 0 = PC/OldPC, 1 = A.
- sel_alu_src_b  in  2  ALU operand B: 00 = B, 01 = imm I/S, 10 = constant 4, 11 = imm J.
- alu_op  in  2  00 = add, 01 = R-type decode, 10 = I-type decode.
- sel_result  in  2  RF write data: 00 = ALUOut, 01 = MDR, 10 = PCPlus4, 11 = imm U.
- we_pc  in  1  PC <= ALU result.
- we_mem  in  1  memory write strobe.
- we_rf  in  1  register file write.
- we_pc_plus_4  in  1  PCPlus4 <= ALU result.
- we_alu_reg  in  1  ALUOut <= ALU result.
- opcode  out  7  IR[6:0], to the FSM.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data, always B.
- mem_we  out  1  equals we_mem.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- dbg_rf_addr  in  5  debug read address.
- dbg_rf_data  out  32  debug read data; x0 reads 0.
- dbg_pc  out  32  current PC.

Behaviour:
- Reset values, applied on the clk edge while rst=1:
  - PC = RESET_PC.
  - OldPC, IR, MDR, A, B, ALUOut, PCPlus4 = 0.
  - All 32 RF entries = 0.
  - rst overrides every write enable in the same cycle.
- Resulting output values during reset:
  - opcode = 0.
  - mem_we follows we_mem combinationally; the driving FSM holds it 0 during reset.
- Decode fields, taken from IR: rs1 = IR[19:15], rs2 = IR[24:20], rd = IR[11:7], funct3 = IR[14:12], funct7b5 = IR[30].
- Unconditional per-cycle updates:
  - A <= RF[rs1], B <= RF[rs2], MDR <= mem_rdata.
  - RF reads are combinational and return 0 for x0.
- When we_ir=1: IR <= mem_rdata and OldPC <= PC, in the same edge.
- Operand A selection:
  - sel_alu_src_a=1 selects A.
  - Otherwise OldPC when sel_alu_src_b=11, else PC.
  - This makes fetch compute PC+4 and JAL compute OldPC+immJ.
- Immediates, all sign-extended to 32 bits:
  - I-type: IR[31:20].
  - S-type: {IR[31:25], IR[11:7]}, selected by src_b=01 when opcode=0100011.
  - J-type: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - U-type: {IR[31:12], 12'b0}.
- ALU, alu_op=00: add.
- ALU, alu_op=01 (R-type), by funct3:
  - 000: sub if funct7b5, else add.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: sra if funct7b5, else srl.
  - 110: or.
  - 111: and.
- ALU, alu_op=10 (I-type): same as R-type, except funct3=000 is always add; srai is selected by funct7b5.
- ALU, alu_op=11: add.
- Shift amount is operand B[4:0]. All arithmetic is modulo 2^32.
- Register writes on the clk edge, each gated by its own enable:
  - PC <= ALU result (we_pc).
  - PCPlus4 <= ALU result (we_pc_plus_4).
  - ALUOut <= ALU result (we_alu_reg).
- RF write: RF[rd] <= selected result when we_rf=1. Writes to rd=0 are discarded.
- Simultaneous RF write and read of the same register: the read returns the old value; there is no bypass. A, B and dbg_rf_data observe the new value from the next cycle.
- Memory port: mem_addr = sel_mem_addr ? ALUOut : PC.
- Memory writes are word-only and 32-bit; address bits [1:0] are passed through unchanged.
- Latency:
  - Every register updates one edge after its enable is sampled.
  - opcode is valid in the cycle after we_ir.
- Undefined control combinations (e.g. we_pc together with we_ir in a non-fetch state) behave per the rules above, with no special casing.

Test Plan:
- Reset with RESET_PC=32'h100: after rst, dbg_pc=32'h100, opcode=0, dbg_rf_data=0 for all addresses. Then a fetch cycle with mem_rdata=32'h00500093 (addi x1,x0,5) -> PC=32'h104, PCPlus4=32'h104, opcode=7'h13.
- addi sequence (fetch, decode, EXE_I, WB sel_result=00) -> x1=5. Then add x2,x1,x1 (32'h00108133) through R-type states -> x2=10. Then sub x3,x2,x1 (32'h401101b3) -> x3=5.
- sw x2,8(x0) (32'h00202423) with EXE_ADDR then MEM_WR -> mem_addr=8, mem_wdata=10, mem_we=1. lw x4,8(x0) with mem_rdata=32'hDEADBEEF in MEM_RD -> x4=32'hDEADBEEF after WB_MEM.
- jal x1,+16 fetched at PC=32'h200 -> after the JAL state PC=32'h210; after WB (sel_result=10) x1=32'h204.
- lui x5,0x12345 (32'h123452b7), WB with sel_result=11 -> x5=32'h12345000. An addi x0,x0,7 writeback -> x0 still reads 0.
- Assert rst during the EXE_R cycle -> on the next edge PC=RESET_PC, ALUOut=0 and no RF write occurs, even though we_rf was asserted that cycle.
